// File: rtl/cam_frame_ctrl.sv
// cam_frame_ctrl
// Write-side controller for the dual-port frame buffer. Consumes the OV7670
// byte stream (vsync/href/px_data, RGB565, high byte first), packs each byte
// pair into one RGB332 pixel and writes an H_PIX x V_LINES frame into the
// buffer at address row*H_PIX + col.
//
// Ports
//   clk          camera pixel clock, all logic on the rising edge
//   rst          synchronous reset, active high
//   start        one-cycle pulse, arms a capture from IDLE
//   cont         1 = re-arm after each frame (sampled at frame end)
//   vsync        camera vsync, high = vertical blanking
//   href         camera href, high = valid bytes on px_data
//   px_data      camera byte
//   mem_px_addr  buffer write address (held between writes)
//   mem_px_data  RGB332 pixel (held between writes)
//   px_wr        buffer write strobe, one cycle per stored pixel
//   busy         high while ARMED or FRAME
//   frame_done   one-cycle pulse when a captured frame ends
//   err_short    sticky: a stored line had fewer than H_PIX pixels;
//                cleared by the next start
module cam_frame_ctrl #(
    parameter int AW      = 15,
    parameter int DW      = 8,    // RGB332 only; must stay 8
    parameter int H_PIX   = 160,
    parameter int V_LINES = 120
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          cont,
    input  logic          vsync,
    input  logic          href,
    input  logic [7:0]    px_data,
    output logic [AW-1:0] mem_px_addr,
    output logic [DW-1:0] mem_px_data,
    output logic          px_wr,
    output logic          busy,
    output logic          frame_done,
    output logic          err_short
);

    // col counts up to and saturates at H_PIX, row up to V_LINES.
    localparam int CW = $clog2(H_PIX + 1);
    localparam int RW = $clog2(V_LINES + 1);

    localparam logic [CW-1:0] H_MAX  = CW'(H_PIX);
    localparam logic [RW-1:0] V_MAX  = RW'(V_LINES);
    localparam logic [AW-1:0] H_STEP = AW'(H_PIX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FRAME = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic          vsync_q, href_q;
    logic          vs_fall, vs_rise, href_fall;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [AW-1:0] base;
    logic          phase;      // 0: expecting high byte, 1: expecting low byte
    logic [7:0]    hi;

    // FSM strobes
    logic          arm;        // IDLE -> ARMED
    logic          frame_go;   // ARMED -> FRAME
    logic          frame_end;  // FRAME -> ARMED/IDLE
    logic          in_line;    // FRAME and the frame is not ending this cycle
    logic          can_store;

    assign vs_fall   = vsync_q & ~vsync;
    assign vs_rise   = ~vsync_q & vsync;
    assign href_fall = href_q & ~href;
    assign busy      = (state != IDLE);

    // vsync rising ends the frame outright, so it takes priority over any
    // byte or line-end activity in the same cycle: a partial line is neither
    // counted nor flagged as short.
    assign in_line   = (state == FRAME) && !vs_rise;
    assign can_store = (col < H_MAX) && (row < V_MAX);

    always_comb begin
        state_nx  = state;
        arm       = 1'b0;
        frame_go  = 1'b0;
        frame_end = 1'b0;
        case (state)
            IDLE: begin
                // A vs_fall coinciding with start only arms; capture waits
                // for the next full frame.
                if (start) begin
                    state_nx = ARMED;
                    arm      = 1'b1;
                end
            end
            ARMED: begin
                if (vs_fall) begin
                    state_nx = FRAME;
                    frame_go = 1'b1;
                end
            end
            FRAME: begin
                if (vs_rise) begin
                    frame_end = 1'b1;
                    state_nx  = cont ? ARMED : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            vsync_q     <= 1'b1;
            href_q      <= 1'b0;
            col         <= '0;
            row         <= '0;
            base        <= '0;
            phase       <= 1'b0;
            hi          <= '0;
            mem_px_addr <= '0;
            mem_px_data <= '0;
            px_wr       <= 1'b0;
            frame_done  <= 1'b0;
            err_short   <= 1'b0;
        end else begin
            state      <= state_nx;
            vsync_q    <= vsync;
            href_q     <= href;
            px_wr      <= 1'b0;
            frame_done <= frame_end;

            if (arm)
                err_short <= 1'b0;

            if (frame_go) begin
                col   <= '0;
                row   <= '0;
                base  <= '0;
                phase <= 1'b0;
            end else if (in_line) begin
                if (href) begin
                    if (!phase) begin
                        hi    <= px_data;
                        phase <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        // Pixels past H_PIX and lines past V_LINES are clipped.
                        if (can_store) begin
                            mem_px_data <= {hi[7:5], hi[2:0], px_data[4:3]};
                            mem_px_addr <= base + AW'(col);
                            px_wr       <= 1'b1;
                            col         <= col + 1'b1;
                        end
                    end
                end else if (href_fall) begin
                    // Only lines that stored at least one pixel consume a row.
                    if (col != '0 && row < V_MAX) begin
                        if (col < H_MAX)
                            err_short <= 1'b1;
                        row  <= row + 1'b1;
                        base <= base + H_STEP;
                    end
                    // An unpaired trailing byte is dropped here.
                    col   <= '0;
                    phase <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_frame_ctrl.sv
module tb_cam_frame_ctrl;
    localparam int AW = 15;
    localparam int DW = 8;
    localparam int H  = 4;
    localparam int V  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1, start = 1'b0, cont = 1'b0;
    logic          vsync = 1'b1, href = 1'b0;
    logic [7:0]    px_data = '0;
    logic [AW-1:0] mem_px_addr;
    logic [DW-1:0] mem_px_data;
    logic          px_wr, busy, frame_done, err_short;

    cam_frame_ctrl #(.AW(AW), .DW(DW), .H_PIX(H), .V_LINES(V)) dut (
        .clk(clk), .rst(rst), .start(start), .cont(cont),
        .vsync(vsync), .href(href), .px_data(px_data),
        .mem_px_addr(mem_px_addr), .mem_px_data(mem_px_data),
        .px_wr(px_wr), .busy(busy), .frame_done(frame_done),
        .err_short(err_short)
    );

    int n_vec = 0, n_err = 0;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;

    wr_t        got_q[$], exp_q[$];
    int         done_cnt = 0;
    logic [7:0] byte_q[$];
    int         len_q[$];

    // Observe writes and frame_done pulses mid-cycle.
    always @(negedge clk) begin
        wr_t w;
        if (px_wr === 1'b1) begin
            w.a = mem_px_addr;
            w.d = mem_px_data;
            got_q.push_back(w);
        end
        if (frame_done === 1'b1) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Hold inputs for one full clock (inputs change on the falling edge).
    task automatic cyc(input logic v, input logic h, input logic [7:0] d);
        vsync = v; href = h; px_data = d;
        @(negedge clk);
    endtask

    task automatic send_line(input int n, input bit rnd);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = rnd ? 8'($urandom) : ((i % 2 == 1) ? 8'h18 : 8'hE3);
            byte_q.push_back(b);
            cyc(1'b0, 1'b1, b);
        end
        len_q.push_back(n);
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic run_frame(input int nl, input int lens[4], input bit rnd, input bit do_start);
        got_q.delete(); byte_q.delete(); len_q.delete();
        done_cnt = 0;
        if (do_start) begin
            start = 1'b1;
            cyc(1'b1, 1'b0, 8'h00);
            start = 1'b0;
            chk("err_clr_on_start", err_short, 0);
        end
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        for (int l = 0; l < nl; l++) send_line(lens[l], rnd);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
    endtask

    // Reference: pixel i of stored line r lands at r*H+i; lines without a
    // complete pixel are skipped; only the first V such lines are stored.
    function automatic void model(output logic e);
        int row = 0;
        int idx = 0;
        wr_t w;
        e = 1'b0;
        exp_q.delete();
        foreach (len_q[l]) begin
            int pix = len_q[l] / 2;
            if (row < V && pix > 0) begin
                int st = (pix < H) ? pix : H;
                for (int i = 0; i < st; i++) begin
                    logic [7:0] hb = byte_q[idx + 2*i];
                    logic [7:0] lb = byte_q[idx + 2*i + 1];
                    w.a = AW'(row * H + i);
                    w.d = {hb[7:5], hb[2:0], lb[4:3]};
                    exp_q.push_back(w);
                end
                if (pix < H) e = 1'b1;
                row++;
            end
            idx += len_q[l];
        end
    endfunction

    task automatic cmp_frame(input string nm);
        logic e;
        model(e);
        chk({nm, "_nwr"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({nm, "_wr"}, got_q[i], exp_q[i]);
        chk({nm, "_err"}, err_short, e);
    endtask

    typedef struct {
        int nl;
        int lens[4];
        int exp_nwr;
        int exp_last;
        bit exp_err;
    } vec_t;

    vec_t tbl[6];

    task automatic set_vec(input int k, input int nl, input int l0, input int l1,
                           input int l2, input int nwr, input int last, input bit err);
        tbl[k].nl = nl;
        tbl[k].lens[0] = l0; tbl[k].lens[1] = l1; tbl[k].lens[2] = l2; tbl[k].lens[3] = 0;
        tbl[k].exp_nwr = nwr; tbl[k].exp_last = last; tbl[k].exp_err = err;
    endtask

    initial begin
        int lens[4];
        int nl;

        set_vec(0, 2,  8, 8, 0, 8, 7, 1'b0);  // basic two-line frame
        set_vec(1, 2, 12, 8, 0, 8, 7, 1'b0);  // long line clipped
        set_vec(2, 1,  5, 0, 0, 2, 1, 1'b1);  // short line, odd byte dropped
        set_vec(3, 3,  8, 8, 8, 8, 7, 1'b0);  // extra line ignored
        set_vec(4, 2,  8, 2, 0, 5, 4, 1'b1);  // second line short
        set_vec(5, 2,  1, 8, 0, 4, 3, 1'b0);  // pixel-less line takes no row

        // Reset, with a start pulse that reset must override.
        start = 1'b1;
        cyc(1'b1, 1'b0, 8'h00);
        start = 1'b0;
        cyc(1'b1, 1'b0, 8'h00);
        chk("reset_outputs", {mem_px_addr, mem_px_data, px_wr, busy, frame_done, err_short}, 0);
        rst = 1'b0;
        cyc(1'b1, 1'b0, 8'h00);
        chk("start_during_rst_busy", busy, 0);

        // Table-driven single-shot frames.
        foreach (tbl[k]) begin
            run_frame(tbl[k].nl, tbl[k].lens, 1'b0, 1'b1);
            chk($sformatf("tbl%0d_nwr", k), got_q.size(), tbl[k].exp_nwr);
            if (got_q.size() > 0)
                chk($sformatf("tbl%0d_last_addr", k), got_q[got_q.size()-1].a, tbl[k].exp_last);
            chk($sformatf("tbl%0d_data0", k), (got_q.size() > 0) ? got_q[0].d : 8'h00, 8'hEF);
            chk($sformatf("tbl%0d_done", k), done_cnt, 1);
            chk($sformatf("tbl%0d_busy", k), busy, 0);
            cmp_frame($sformatf("tbl%0d", k));
            repeat (4) cyc(1'b1, 1'b0, 8'h00);
            chk($sformatf("tbl%0d_err_hold", k), err_short, tbl[k].exp_err);
        end

        // Continuous capture: two frames back to back, cont dropped for the second.
        lens = '{8, 8, 0, 0};
        cont = 1'b1;
        run_frame(2, lens, 1'b0, 1'b1);
        cmp_frame("cont_f1");
        chk("cont_f1_done", done_cnt, 1);
        chk("cont_f1_busy", busy, 1);
        cont = 1'b0;
        run_frame(2, lens, 1'b1, 1'b0);
        cmp_frame("cont_f2");
        chk("cont_f2_done", done_cnt, 1);
        chk("cont_f2_busy", busy, 0);

        // start coinciding with vsync falling: only arms.
        got_q.delete();
        start = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        start = 1'b0;
        send_line(8, 1'b0);
        chk("start_vsfall_nowr", got_q.size(), 0);
        chk("start_vsfall_busy", busy, 1);
        lens = '{8, 0, 0, 0};
        run_frame(1, lens, 1'b1, 1'b0);
        cmp_frame("start_vsfall_next");
        chk("start_vsfall_done", done_cnt, 1);

        // Reset in the middle of a line after 3 stored pixels.
        got_q.delete();
        start = 1'b1;
        cyc(1'b1, 1'b0, 8'h00);
        start = 1'b0;
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, (i % 2 == 1) ? 8'h18 : 8'hE3);
        rst = 1'b1;
        start = 1'b1;
        cyc(1'b0, 1'b1, 8'hE3);
        chk("rst_mid_outputs", {mem_px_addr, mem_px_data, px_wr, busy, frame_done, err_short}, 0);
        rst = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'h18);
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 8'hE3);
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        chk("rst_mid_nwr", got_q.size(), 3);
        chk("rst_mid_busy", busy, 0);

        // Randomized single-shot frames against the reference model.
        for (int f = 0; f < 12; f++) begin
            nl = $urandom_range(0, 4);
            for (int l = 0; l < 4; l++) lens[l] = $urandom_range(0, 12);
            run_frame(nl, lens, 1'b1, 1'b1);
            cmp_frame($sformatf("rnd%0d", f));
            chk($sformatf("rnd%0d_done", f), done_cnt, 1);
            chk($sformatf("rnd%0d_busy", f), busy, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
